out_capture_fifo: RTL and testbench

Output-capture stage that sits directly downstream of the CPU's 16-bit `out` port. Each cycle it compares `out` against its previous value. Every change becomes one entry in a small first-word-fall-through FIFO. A host or testbench drains the FIFO with a valid/ready handshake. Overflow is reported with a sticky flag and a saturating drop counter, so program output is never lost silently.

---
 rtl/out_capture_fifo_if.sv | 19 +
 rtl/out_capture_fifo.sv | 110 +++++++++++
 tb/tb_out_capture_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/out_capture_fifo_if.sv
// out_capture_fifo_if
//   Valid/ready stream carrying captured CPU output words out of the capture FIFO.
//   Ports (signals):
//     m_data  [WIDTH] head-of-FIFO word, meaningful only while m_valid=1
//     m_valid         FIFO holds at least one entry
//     m_ready         consumer accepts the head entry this cycle
//   Modports:
//     master  producer side (the FIFO): drives m_data/m_valid, reads m_ready
//     slave   consumer side: reads m_data/m_valid, drives m_ready
interface out_capture_fifo_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input  m_ready);
  modport slave  (input  m_data, input  m_valid, output m_ready);
endinterface

// File: rtl/out_capture_fifo.sv
// out_capture_fifo
//   Watches the CPU 16-bit out port, turns every change of value into one entry of
//   a small first-word-fall-through FIFO, and reports pushes lost to a full FIFO
//   through a sticky overflow flag and a saturating drop counter.
//   Parameters: WIDTH data width, DEPTH entries (power of 2, >= 2), CNT_W drop-counter width.
//   Ports:
//     clk       rising-edge clock
//     reset     asynchronous, active-low reset
//     cpu_out   CPU out port, sampled every cycle
//     cap_en    capture enable (change tracking continues while 0)
//     clr_ovf   synchronous clear of overflow/drop_cnt (a same-cycle drop wins)
//     m_if      master side of the output stream (m_data, m_valid, m_ready)
//     level     occupancy 0..DEPTH
//     overflow  sticky, set on any dropped push
//     drop_cnt  dropped-push count, saturating at all-ones
module out_capture_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         cpu_out,
  input  logic                     cap_en,
  input  logic                     clr_ovf,
  out_capture_fifo_if.master       m_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Storage is deliberately left out of reset so it can map onto plain RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] prev_q,     prev_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [LVL_W-1:0] level_q,    level_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic chg, push, pop, full, accept, drop;

  always_comb begin
    chg    = (cpu_out != prev_q);
    push   = cap_en & chg;
    pop    = (level_q != '0) & m_if.m_ready;
    full   = (level_q == LVL_W'(DEPTH));
    // A pop in the same cycle frees the slot the push needs, so full+pop still accepts.
    accept = push & (~full | pop);
    drop   = push & full & ~pop;

    // prev follows cpu_out unconditionally so that re-enabling capture does not
    // report a change that happened while capture was off.
    prev_d     = cpu_out;
    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    if (accept && !pop)      level_d = level_q + 1'b1;
    else if (!accept && pop) level_d = level_q - 1'b1;

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      // The drop outranks a simultaneous clear: the count restarts at one.
      if (clr_ovf)                drop_cnt_d = CNT_W'(1);
      else if (drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Write port only; gated by accept so a dropped push never corrupts the head.
  always_ff @(posedge clk) begin
    if (reset && accept) mem_q[wr_ptr_q] <= cpu_out;
  end

  // First-word fall-through: the head is read combinationally from rd_ptr, so it
  // holds still while the consumer stalls and only moves after a pop.
  assign m_if.m_data  = mem_q[rd_ptr_q];
  assign m_if.m_valid = (level_q != '0);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_out_capture_fifo.sv
// tb_out_capture_fifo
//   Directed bench for out_capture_fifo. Every issued change is pushed into a
//   scoreboard queue; entries are popped and compared as the FIFO delivers them.
module tb_out_capture_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] cpu_out;
  logic             cap_en;
  logic             clr_ovf;
  logic [3:0]       level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  out_capture_fifo_if #(.WIDTH(WIDTH)) bus ();

  out_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_out  (cpu_out),
    .cap_en   (cap_en),
    .clr_ovf  (clr_ovf),
    .m_if     (bus),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] m_prev;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict this edge from the driven inputs, compare popped data,
  // let the edge happen, then compare status 1 time unit later.
  task automatic step();
    if (sb_q.size() != 0 && bus.m_ready) begin
      chk("pop_data", 32'(bus.m_data), 32'(sb_q[0]));
      $display("t=%0t pop  data=%h exp=%h", $time, bus.m_data, sb_q[0]);
      void'(sb_q.pop_front());
    end
    if (cap_en && cpu_out != m_prev) begin
      if (sb_q.size() < DEPTH) begin
        sb_q.push_back(cpu_out);
        $display("t=%0t push data=%h", $time, cpu_out);
      end else begin
        m_ovf = 1'b1;
        if (clr_ovf)          m_cnt = 8'd1;
        else if (m_cnt != '1) m_cnt = m_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      m_ovf = 1'b0;
      m_cnt = '0;
    end
    m_prev = cpu_out;
    @(posedge clk);
    #1;
    chk("level",    32'(level),       32'(sb_q.size()));
    chk("m_valid",  32'(bus.m_valid), 32'(sb_q.size() != 0));
    chk("overflow", 32'(overflow),    32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt),    32'(m_cnt));
  endtask

  task automatic drain();
    int budget = 40;
    bus.m_ready = 1'b1;
    while (sb_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_done", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; cpu_out = '0; cap_en = 1'b1; clr_ovf = 1'b0; bus.m_ready = 1'b0;
    m_prev = '0; m_ovf = 1'b0; m_cnt = '0;
    #1;
    chk("rst_level",    32'(level),       32'd0);
    chk("rst_valid",    32'(bus.m_valid), 32'd0);
    chk("rst_overflow", 32'(overflow),    32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt),    32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Single change: visible one edge later, then popped.
    cpu_out = 16'd3; step();
    chk("first_valid", 32'(bus.m_valid), 32'd1);
    chk("first_data",  32'(bus.m_data),  32'd3);
    chk("first_level", 32'(level),       32'd1);
    bus.m_ready = 1'b1; step();
    chk("first_popped", 32'(bus.m_valid), 32'd0);

    // Fill with back-to-back changes, then one more overflows.
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin cpu_out = 16'(i); step(); end
    chk("full_level", 32'(level), 32'd8);
    cpu_out = 16'd9; step();
    chk("ovf_set",  32'(overflow), 32'd1);
    chk("ovf_cnt1", 32'(drop_cnt), 32'd1);
    chk("head_stable", 32'(bus.m_data), 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    cpu_out = 16'hABCD; bus.m_ready = 1'b1; step();
    chk("swap_level", 32'(level),    32'd8);
    chk("swap_ovf",   32'(overflow), 32'd0);
    drain();

    // Changes while disabled are not captured; re-enabling on a held value adds nothing.
    cap_en = 1'b0;
    cpu_out = 16'd5; step();
    cpu_out = 16'd6; step();
    cpu_out = 16'd7; step();
    cap_en = 1'b1; step();
    chk("cap_dis_level", 32'(level), 32'd0);
    bus.m_ready = 1'b0;
    cpu_out = 16'd8; step();
    chk("cap_en_level", 32'(level),       32'd1);
    chk("cap_en_data",  32'(bus.m_data),  32'd8);
    drain();

    // Return to a previous value is a new transition.
    bus.m_ready = 1'b0;
    cpu_out = 16'd9; step();
    cpu_out = 16'd8; step();
    chk("return_level", 32'(level), 32'd2);
    drain();

    // Saturating drop counter.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin cpu_out = 16'(16'h100 + i); step(); end
    for (int i = 0; i < 300; i++) begin cpu_out = 16'(16'h1000 + i); step(); end
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    clr_ovf = 1'b1; step();
    chk("clr_alone_ovf", 32'(overflow), 32'd0);
    chk("clr_alone_cnt", 32'(drop_cnt), 32'd0);
    cpu_out = 16'h2222; step(); clr_ovf = 1'b0;
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);

    // Bring level to 5, then reset asynchronously between edges.
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.m_ready = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("async_level", 32'(level),       32'd0);
    chk("async_valid", 32'(bus.m_valid), 32'd0);
    sb_q.delete(); m_prev = '0; m_ovf = 1'b0; m_cnt = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_out = 16'h55AA; step();
    chk("post_rst_data", 32'(bus.m_data), 32'h55AA);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
